// File: rtl/digit_frame_ctrl.sv
// Frame sequencer: start -> vsync align -> projection (with retry) -> border -> feature -> latch result.
// Latency: outputs registered; done/result appear 1 cycle after the vsync rise that ends the feature frame.
// No backpressure: start is dropped while busy, abort cancels any run immediately.
module digit_frame_ctrl #(
    parameter int NUM_ROW   = 1,
    parameter int NUM_COL   = 7,
    parameter int MAX_RETRY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        vsync,
    input  logic [3:0]  num_row,
    input  logic [3:0]  num_col,
    input  logic [19:0] digit_in,
    output logic [1:0]  frame_cnt,
    output logic        project_done_flag,
    output logic        busy,
    output logic        done,
    output logic [19:0] result,
    output logic        result_ok,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_PROJ,
        S_BORDER,
        S_FEAT,
        S_LATCH
    } state_t;

    localparam logic [7:0] EXP_CNT   = 8'(NUM_ROW * NUM_COL);
    localparam logic [1:0] RETRY_MAX = 2'(MAX_RETRY);

    state_t      state;
    state_t      state_nxt;
    logic        vsync_d;
    logic        vs_rise;
    logic [7:0]  prod;
    logic [7:0]  cnt;
    logic [7:0]  cnt_nxt;
    logic [1:0]  retry_cnt;
    logic [1:0]  retry_nxt;
    logic        err_nxt;
    logic [1:0]  frame_cnt_nxt;
    logic        pdf_nxt;
    logic        latch_en;

    assign vs_rise = vsync & ~vsync_d;
    assign prod    = {4'd0, num_row} * {4'd0, num_col};

    // Next-state, retry/error bookkeeping and next registered output values.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        retry_nxt = retry_cnt;
        err_nxt   = err;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state_nxt = S_SYNC;
                        err_nxt   = 1'b0;
                        retry_nxt = 2'd0;
                    end
                end
                S_SYNC: begin
                    if (vs_rise) state_nxt = S_PROJ;
                end
                S_PROJ: begin
                    if (vs_rise) begin
                        cnt_nxt = prod;
                        if (prod != 8'd0) begin
                            state_nxt = S_BORDER;
                        end else if (retry_cnt < RETRY_MAX) begin
                            retry_nxt = 2'(retry_cnt + 2'd1);
                        end else begin
                            err_nxt   = 1'b1;
                            state_nxt = S_IDLE;
                        end
                    end
                end
                S_BORDER: begin
                    if (vs_rise) state_nxt = S_FEAT;
                end
                S_FEAT: begin
                    if (vs_rise) state_nxt = S_LATCH;
                end
                S_LATCH: begin
                    state_nxt = S_IDLE;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end

        frame_cnt_nxt = 2'd0;
        pdf_nxt       = 1'b0;
        unique case (state_nxt)
            S_BORDER: begin
                frame_cnt_nxt = 2'd1;
                pdf_nxt       = 1'b1;
            end
            S_FEAT, S_LATCH: begin
                frame_cnt_nxt = 2'd2;
                pdf_nxt       = 1'b1;
            end
            default: begin
                frame_cnt_nxt = 2'd0;
                pdf_nxt       = 1'b0;
            end
        endcase

        latch_en = (state == S_FEAT) && (state_nxt == S_LATCH);
    end

    // State register plus registered outputs derived from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= S_IDLE;
            vsync_d           <= 1'b0;
            cnt               <= 8'd0;
            retry_cnt         <= 2'd0;
            err               <= 1'b0;
            frame_cnt         <= 2'd0;
            project_done_flag <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
        end else begin
            state             <= state_nxt;
            vsync_d           <= vsync;
            cnt               <= cnt_nxt;
            retry_cnt         <= retry_nxt;
            err               <= err_nxt;
            frame_cnt         <= frame_cnt_nxt;
            project_done_flag <= pdf_nxt;
            busy              <= (state_nxt != S_IDLE);
            done              <= (state_nxt == S_LATCH);
        end
    end

    // Capture the recogniser word on the edge that enters LATCH so it is valid with done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result    <= 20'd0;
            result_ok <= 1'b0;
        end else if (latch_en) begin
            result    <= digit_in;
            result_ok <= (cnt == EXP_CNT);
        end
    end

endmodule

// File: tb/tb_digit_frame_ctrl.sv
// Directed bench for digit_frame_ctrl with a result scoreboard.
// Expected results are queued when a run is launched and checked when done pulses.
// Step outputs are sampled 1 time unit after the clock edge; done is sampled on negedge.
module tb_digit_frame_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic        vsync;
    logic [3:0]  num_row;
    logic [3:0]  num_col;
    logic [19:0] digit_in;
    logic [1:0]  frame_cnt;
    logic        project_done_flag;
    logic        busy;
    logic        done;
    logic [19:0] result;
    logic        result_ok;
    logic        err;

    typedef struct {
        logic [19:0] res;
        logic        ok;
    } exp_t;

    exp_t sb[$];
    exp_t exp_e;
    int   total  = 0;
    int   bad    = 0;
    int   n_done = 0;

    digit_frame_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .abort             (abort),
        .vsync             (vsync),
        .num_row           (num_row),
        .num_col           (num_col),
        .digit_in          (digit_in),
        .frame_cnt         (frame_cnt),
        .project_done_flag (project_done_flag),
        .busy              (busy),
        .done              (done),
        .result            (result),
        .result_ok         (result_ok),
        .err               (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Low gap, then one-cycle vsync high; returns just after the edge that sees the rise.
    task automatic vs_pulse();
        tick(3);
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Scoreboard check on every done pulse.
    always @(negedge clk) begin
        if (!rst && done) begin
            n_done++;
            chk("done_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                exp_e = sb.pop_front();
                chk("sb_result", 32'(result), 32'(exp_e.res));
                chk("sb_result_ok", 32'(result_ok), 32'(exp_e.ok));
            end
        end
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        vsync    = 1'b0;
        num_row  = 4'd0;
        num_col  = 4'd0;
        digit_in = 20'd0;
        tick(2);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_pdf", 32'(project_done_flag), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_result_ok", 32'(result_ok), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        tick(2);

        // Nominal run, vsync already high when SYNC is entered.
        num_row  = 4'd1;
        num_col  = 4'd7;
        digit_in = 20'h12345;
        vsync    = 1'b1;
        tick(2);
        sb.push_back('{res: 20'h12345, ok: 1'b1});
        do_start();
        tick(2);
        chk("nom_sync_busy", 32'(busy), 32'd1);
        chk("nom_sync_fc", 32'(frame_cnt), 32'd0);
        vsync = 1'b0;
        vs_pulse();
        chk("nom_proj_fc", 32'(frame_cnt), 32'd0);
        chk("nom_proj_pdf", 32'(project_done_flag), 32'd0);
        vs_pulse();
        chk("nom_border_fc", 32'(frame_cnt), 32'd1);
        chk("nom_border_pdf", 32'(project_done_flag), 32'd1);
        vs_pulse();
        chk("nom_feat_fc", 32'(frame_cnt), 32'd2);
        chk("nom_feat_pdf", 32'(project_done_flag), 32'd1);
        chk("nom_feat_done", 32'(done), 32'd0);
        vs_pulse();
        chk("nom_latch_done", 32'(done), 32'd1);
        chk("nom_latch_result", 32'(result), 32'h12345);
        chk("nom_latch_ok", 32'(result_ok), 32'd1);
        chk("nom_latch_fc", 32'(frame_cnt), 32'd2);
        tick();
        chk("nom_after_done", 32'(done), 32'd0);
        chk("nom_after_busy", 32'(busy), 32'd0);
        chk("nom_after_fc", 32'(frame_cnt), 32'd0);
        chk("nom_after_pdf", 32'(project_done_flag), 32'd0);
        chk("nom_ndone", 32'(n_done), 32'd1);

        // Partial detection; vsync rise coincident with start must be ignored.
        num_col  = 4'd5;
        digit_in = 20'hABCDE;
        sb.push_back('{res: 20'hABCDE, ok: 1'b0});
        vsync = 1'b1;
        do_start();
        vsync = 1'b0;
        vs_pulse();
        chk("part_proj_fc", 32'(frame_cnt), 32'd0);
        vs_pulse();
        chk("part_border_fc", 32'(frame_cnt), 32'd1);
        vs_pulse();
        chk("part_feat_fc", 32'(frame_cnt), 32'd2);
        vs_pulse();
        chk("part_done", 32'(done), 32'd1);
        chk("part_ok", 32'(result_ok), 32'd0);
        tick();
        chk("part_ndone", 32'(n_done), 32'd2);

        // Empty projection: four PROJ frames then error, no done.
        num_row = 4'd0;
        num_col = 4'd7;
        do_start();
        vs_pulse();
        for (int i = 0; i < 3; i++) begin
            vs_pulse();
            chk("empty_retry_busy", 32'(busy), 32'd1);
            chk("empty_retry_fc", 32'(frame_cnt), 32'd0);
            chk("empty_retry_err", 32'(err), 32'd0);
        end
        vs_pulse();
        chk("empty_err", 32'(err), 32'd1);
        chk("empty_busy", 32'(busy), 32'd0);
        chk("empty_done", 32'(done), 32'd0);
        tick(2);
        chk("empty_ndone", 32'(n_done), 32'd2);

        // Retry recovery: one empty frame, then normal completion; start clears err.
        digit_in = 20'h0F00D;
        sb.push_back('{res: 20'h0F00D, ok: 1'b1});
        do_start();
        chk("rec_err_clear", 32'(err), 32'd0);
        chk("rec_busy", 32'(busy), 32'd1);
        vs_pulse();
        vs_pulse();
        chk("rec_retry_fc", 32'(frame_cnt), 32'd0);
        chk("rec_retry_busy", 32'(busy), 32'd1);
        num_row = 4'd1;
        vs_pulse();
        chk("rec_border_fc", 32'(frame_cnt), 32'd1);
        vs_pulse();
        chk("rec_feat_fc", 32'(frame_cnt), 32'd2);
        vs_pulse();
        chk("rec_done", 32'(done), 32'd1);
        chk("rec_result", 32'(result), 32'h0F00D);
        tick();
        chk("rec_ndone", 32'(n_done), 32'd3);

        // Abort in BORDER, with an ignored start while busy.
        digit_in = 20'h55555;
        do_start();
        vs_pulse();
        vs_pulse();
        chk("abt_border_pdf", 32'(project_done_flag), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("abt_busy_start_fc", 32'(frame_cnt), 32'd1);
        chk("abt_busy_start_busy", 32'(busy), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abt_busy", 32'(busy), 32'd0);
        chk("abt_pdf", 32'(project_done_flag), 32'd0);
        chk("abt_fc", 32'(frame_cnt), 32'd0);
        chk("abt_done", 32'(done), 32'd0);
        chk("abt_result", 32'(result), 32'h0F00D);
        chk("abt_result_ok", 32'(result_ok), 32'd1);
        tick(3);
        chk("abt_idle_busy", 32'(busy), 32'd0);

        // Start and abort together: stays idle.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", 32'(busy), 32'd0);
        tick(2);
        chk("sa_busy_later", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of FEAT.
        do_start();
        vs_pulse();
        vs_pulse();
        vs_pulse();
        chk("rstf_feat_fc", 32'(frame_cnt), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("rstf_fc", 32'(frame_cnt), 32'd0);
        chk("rstf_pdf", 32'(project_done_flag), 32'd0);
        chk("rstf_busy", 32'(busy), 32'd0);
        chk("rstf_result", 32'(result), 32'd0);
        chk("rstf_done", 32'(done), 32'd0);
        tick(2);
        rst = 1'b0;
        tick(2);

        chk("final_ndone", 32'(n_done), 32'd3);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/digit_frame_ctrl.md
# digit_frame_ctrl

Frame-level sequencer for the digit-recognition datapath. It takes a software start request, aligns to the video vertical sync, and drives `frame_cnt` and `project_done_flag` through the three-frame sequence: projection, border fetch, then feature extraction. It retries when projection finds no digits, latches the 20-bit recognised digit word, and reports done and error status to the Cortex-M3 register interface.

## Interface
Parameters:
- `NUM_ROW`, 1: expected digit rows.
- `NUM_COL`, 7: expected digit columns.
- `MAX_RETRY`, 3: extra projection attempts allowed after an empty projection (2 bits used).

Ports:
- `clk`, in, 1: pixel clock, the only clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `start`, in, 1: one-cycle request from the register interface; ignored unless the FSM is in IDLE.
- `abort`, in, 1: one-cycle cancel; returns the FSM to IDLE from any state.
- `vsync`, in, 1: vertical sync, synchronous to `clk`; its rising edge marks a frame boundary.
- `num_row`, in, 4: digit rows found by projection; valid at the end of frame 0.
- `num_col`, in, 4: digit columns found by projection; valid at the end of frame 0.
- `digit_in`, in, 20: recognised digit word from the recogniser; valid at the end of frame 2.
- `frame_cnt`, out, 2: current sequence frame (0, 1 or 2).
- `project_done_flag`, out, 1: enables border and feature processing in the recogniser.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse when a result is latched.
- `result`, out, 20: latched digit word.
- `result_ok`, out, 1: found digit count equals `NUM_ROW*NUM_COL`.
- `err`, out, 1: retries exhausted with no digits found; sticky until the next accepted `start`.

## Operation
- Edge detect: `vsync_d` is a registered copy of `vsync`. `vs_rise = vsync & ~vsync_d`.
- States: IDLE, SYNC, PROJ, BORDER, FEAT, LATCH.
- IDLE
  - On `start`: go to SYNC, clear `err`, load `retry_cnt` with 0.
- SYNC
  - On `vs_rise`: go to PROJ.
- PROJ (frame 0)
  - On `vs_rise`, register `cnt = num_row*num_col` (8-bit unsigned).
  - If `cnt != 0`: go to BORDER.
  - Else if `retry_cnt < MAX_RETRY`: increment `retry_cnt` and stay in PROJ for another projection frame.
  - Else: set `err` and go to IDLE. `done` does not pulse.
- BORDER (frame 1)
  - On `vs_rise`: go to FEAT.
- FEAT (frame 2)
  - On `vs_rise`: go to LATCH.
- LATCH (one cycle)
  - `result <= digit_in`.
  - `result_ok <= (cnt == NUM_ROW*NUM_COL)`.
  - `done` = 1 for this cycle.
  - Then go to IDLE.
- Outputs by state:
  - `frame_cnt`: 0 in IDLE, SYNC and PROJ; 1 in BORDER; 2 in FEAT and LATCH.
  - `project_done_flag`: 1 in BORDER, FEAT and LATCH only.
- Abort: `abort` has priority over every other transition. The next state is IDLE. `frame_cnt` goes to 0 and `project_done_flag` to 0. `result`, `result_ok` and `err` are unchanged. `done` does not pulse.
- `start` while `busy` is ignored. `start` and `abort` in the same cycle: `abort` wins, and the FSM stays in IDLE.
- Reset values: state IDLE, `frame_cnt` 0, `project_done_flag` 0, `busy` 0, `done` 0, `result` 0, `result_ok` 0, `err` 0, `retry_cnt` 0, `vsync_d` 0.
- An assertion of `rst` at any point forces all of the above immediately (asynchronous).

## Timing
- All outputs are registered. They change on the clock edge where the transition condition is true.
- Start to first frame: start accepted at edge N → SYNC at N+1 → PROJ on the first later edge with `vs_rise`.
- If `vsync` is already high when SYNC is entered, the FSM waits for the next rising edge. It never starts mid-frame.
- `vs_rise` in the same cycle as `start`: not used. It is sampled only from SYNC onward.
- `frame_cnt` updates on the same edge as the `vs_rise` transition, so the recogniser sees the new frame from the first cycle after vsync.
- Latency from the vsync that ends FEAT to `done`: 1 cycle (LATCH). `result` is valid on the same edge that `done` goes high.
- A minimal successful run spans 4 `vs_rise` events after `start`: SYNC→PROJ, PROJ→BORDER, BORDER→FEAT, FEAT→LATCH.
- Each empty-projection retry adds 1 frame.
- Back-to-back runs: the earliest accepted `start` is the cycle after `done`.

## Test plan
- Reset with `rst` high mid-FEAT → same cycle: `frame_cnt`=0, `project_done_flag`=0, `busy`=0, `result`=0.
- Nominal run: `start`, `num_row`=1, `num_col`=7, `digit_in`=20'h12345 → `frame_cnt` 0→1→2 on successive vsyncs, `project_done_flag` high for 2 frames, `done` pulses once 1 cycle after the 4th `vs_rise`, `result`=20'h12345, `result_ok`=1.
- Partial detection: `num_col`=5 → `done` pulses, `result_ok`=0.
- Empty projection, `num_row`=0 for 4 frames, `MAX_RETRY`=3 → 4 PROJ frames, `err`=1, `done` never pulses. A later `start` clears `err`.
- Retry recovery: `num_row`=0 for frame 1 of PROJ, then 1 → exactly one extra PROJ frame, then a normal completion.
- `abort` in BORDER, plus `start` while busy → immediate IDLE with `project_done_flag`=0; the mid-run `start` has no effect; `result` keeps its previous value.
